// File: rtl/s1_pkg.sv
// ============================================================================
// Module   : s1_pkg
// Purpose  : Shared types and select decode for the S1 select/distribute cells
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package s1_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_t;

  // ACT-style select decode: S1 = A1|B1, S0 = A0&B0
  function automatic lane_t sel_decode(input logic a1, input logic b1,
                                       input logic a0, input logic b0);
    return {a1 | b1, a0 & b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/s1_lane.sv
// ============================================================================
// Module   : s1_lane
// Purpose  : One holding lane; a load wins over an ack so refill keeps it full
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module s1_lane #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         ack,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         full
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= din;
      full <= 1'b1;
    end else if (ack) begin
      full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/s1_dist.sv
// ============================================================================
// Module   : s1_dist
// Purpose  : Registered 1-to-4 distributor with select or round-robin steering
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module s1_dist
  import s1_pkg::*;
#(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         A1,
  input  logic         B1,
  input  logic         A0,
  input  logic         B0,
  input  logic         rr,
  input  logic [3:0]   ack,
  output logic [N-1:0] q0,
  output logic [N-1:0] q1,
  output logic [N-1:0] q2,
  output logic [N-1:0] q3,
  output logic [3:0]   full,
  output logic         ovf
);

  lane_t                  ptr;
  lane_t                  tgt;
  logic                   accept;
  logic [LANES-1:0]       load;
  logic [LANES-1:0][N-1:0] q_arr;

  assign tgt      = rr ? ptr : sel_decode(A1, B1, A0, B0);
  assign in_ready = ~full[tgt] | ack[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) load[tgt] = 1'b1;
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      s1_lane #(.N(N)) u_lane (
        .clk  (clk),
        .clr  (clr),
        .load (load[i]),
        .ack  (ack[i]),
        .din  (din),
        .q    (q_arr[i]),
        .full (full[i])
      );
    end
  endgenerate

  assign q0 = q_arr[0];
  assign q1 = q_arr[1];
  assign q2 = q_arr[2];
  assign q3 = q_arr[3];

  // Pointer only moves on a round-robin accept, so select mode leaves it parked
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept && rr) ptr <= ptr + 2'd1;
      if (in_valid && !in_ready) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire
